// File: rtl/tmr_irq_pkg.sv
// Shared constants and types for the timer interrupt controller.
// Used by tmr_irq_ctrl and tmr_irq_edge.
package tmr_irq_pkg;

    localparam logic [7:0] ADDR_IER  = 8'h00;
    localparam logic [7:0] ADDR_ISR  = 8'h01;
    localparam logic [7:0] ADDR_ICNT = 8'h02;

    localparam int IRQ_OVF_BIT = 0;
    localparam int IRQ_UDF_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/tmr_irq_edge.sv
// Rising-edge detector for one timer status flag. A flag that is already high
// when reset is released is absorbed on the first clock instead of firing.
module tmr_irq_edge
    import tmr_irq_pkg::*;
(
    input  logic pclk,
    input  logic preset,
    input  logic flag,
    output logic rise
);

    logic flag_d;
    logic armed;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            flag_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            flag_d <= flag;
            armed  <= 1'b1;
        end
    end

    assign rise = flag & ~flag_d & armed;

endmodule

// File: rtl/tmr_irq_ctrl.sv
// Maskable sticky interrupt controller for timer_8bit overflow/underflow flags,
// with a zero-wait APB slave. Define TMR_IRQ_CNT_EN to add the ICNT event counter.
module tmr_irq_ctrl
    import tmr_irq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              tmr_ovf,
    input  logic              tmr_udf,
    output logic              irq
);

    apb_state_e state_q;
    apb_state_e state_d;

    logic       acc;
    logic       wr_acc;
    logic       rd_acc;
    logic       sel_ier;
    logic       sel_isr;
    logic       sel_icnt;
    logic       mapped;
    logic [1:0] rise;
    logic [1:0] w1c;
    logic [1:0] ier;
    logic [1:0] isr;
    logic       unused_wdata;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                if (psel && penable) state_d = ACCESS;
                else if (psel)       state_d = SETUP;
            end
            ACCESS: begin
                if (psel && !penable) state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus is in its ACCESS phase exactly when the FSM is entering ACCESS.
    assign acc    = (state_d == ACCESS);
    assign wr_acc = acc & pwrite;
    assign rd_acc = acc & ~pwrite;

    assign sel_ier = (paddr == ADDR_W'(ADDR_IER));
    assign sel_isr = (paddr == ADDR_W'(ADDR_ISR));
`ifdef TMR_IRQ_CNT_EN
    assign sel_icnt = (paddr == ADDR_W'(ADDR_ICNT));
`else
    assign sel_icnt = 1'b0;
`endif
    assign mapped = sel_ier | sel_isr | sel_icnt;

    tmr_irq_edge u_edge_ovf (
        .pclk   (pclk),
        .preset (preset),
        .flag   (tmr_ovf),
        .rise   (rise[IRQ_OVF_BIT])
    );

    tmr_irq_edge u_edge_udf (
        .pclk   (pclk),
        .preset (preset),
        .flag   (tmr_udf),
        .rise   (rise[IRQ_UDF_BIT])
    );

    assign w1c = (wr_acc && sel_isr) ? pwdata[1:0] : 2'b00;

    // A new rise beats a same-cycle clear, so no event is ever lost.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ier <= 2'b00;
            isr <= 2'b00;
            irq <= 1'b0;
        end else begin
            if (wr_acc && sel_ier) ier <= pwdata[1:0];
            isr <= (isr & ~w1c) | rise;
            irq <= |(isr & ier);
        end
    end

`ifdef TMR_IRQ_CNT_EN
    logic [CNT_W-1:0] icnt;
    logic [1:0]       n_rise;
    logic [CNT_W:0]   cnt_sum;

    assign n_rise  = {1'b0, rise[0]} + {1'b0, rise[1]};
    assign cnt_sum = {1'b0, icnt} + {{(CNT_W-1){1'b0}}, n_rise};

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            icnt <= '0;
        end else if (wr_acc && sel_icnt) begin
            icnt <= {{(CNT_W-2){1'b0}}, n_rise};
        end else if (cnt_sum[CNT_W]) begin
            icnt <= '1;
        end else begin
            icnt <= cnt_sum[CNT_W-1:0];
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

    always_comb begin
        prdata = '0;
        if (rd_acc) begin
            if (sel_ier)      prdata = {{(DATA_W-2){1'b0}}, ier};
            else if (sel_isr) prdata = {{(DATA_W-2){1'b0}}, isr};
`ifdef TMR_IRQ_CNT_EN
            else if (sel_icnt) prdata = DATA_W'(icnt);
`endif
        end
    end

    assign pslverr = acc & ~mapped;
    assign pready  = 1'b1;

    assign unused_wdata = ^pwdata[DATA_W-1:2];

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// Self-checking bench for tmr_irq_ctrl: directed scenarios plus randomized
// flag/APB traffic against a cycle-level behavioural model of the register file.
module tb_tmr_irq_ctrl;

    logic       pclk    = 1'b0;
    logic       preset  = 1'b1;
    logic       psel    = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf = 1'b0;
    logic       tmr_udf = 1'b0;
    logic       irq;

    tmr_irq_ctrl #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [1:0] m_ier;
    logic [1:0] m_isr;
    logic       m_irq;
    int         m_cnt;
    logic       m_ovf_last;
    logic       m_udf_last;
    logic       m_seen_clk;
    logic       m_acc = 1'b0;

    task automatic m_reset();
        m_ier = 2'b00; m_isr = 2'b00; m_irq = 1'b0; m_cnt = 0;
        m_ovf_last = 1'b0; m_udf_last = 1'b0; m_seen_clk = 1'b0;
    endtask

    function automatic logic m_err(input logic [7:0] a);
`ifdef TMR_IRQ_CNT_EN
        return a > 8'h02;
`else
        return a > 8'h01;
`endif
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a == 8'h00) return {6'b0, m_ier};
        if (a == 8'h01) return {6'b0, m_isr};
`ifdef TMR_IRQ_CNT_EN
        if (a == 8'h02) return m_cnt[7:0];
`endif
        return 8'h00;
    endfunction

    // Advance one clock and apply the register rules to the model.
    task automatic tick();
        @(posedge pclk);
        if (!preset) begin
            logic ro, ru;
            logic [1:0] clr;
            int nr;
            ro = tmr_ovf && !m_ovf_last && m_seen_clk;
            ru = tmr_udf && !m_udf_last && m_seen_clk;
            nr = (ro ? 1 : 0) + (ru ? 1 : 0);
            m_irq = |(m_isr & m_ier);
            clr = (m_acc && pwrite && paddr == 8'h01) ? pwdata[1:0] : 2'b00;
            if (m_acc && pwrite && paddr == 8'h00) m_ier = pwdata[1:0];
            m_isr = (m_isr & ~clr) | {ru, ro};
            if (m_acc && pwrite && paddr == 8'h02) m_cnt = nr;
            else m_cnt = (m_cnt + nr > 255) ? 255 : m_cnt + nr;
            m_ovf_last = tmr_ovf;
            m_udf_last = tmr_udf;
            m_seen_clk = 1'b1;
        end
        #1;
    endtask

    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic ovf_at_acc,
                       output logic [7:0] rd, output logic er,
                       output logic [7:0] erd, output logic eer);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick();
        penable = 1'b1; m_acc = 1'b1;
        if (ovf_at_acc) tmr_ovf = 1'b1;
        #3;
        rd  = prdata;
        er  = pslverr;
        erd = m_read(a);
        eer = m_err(a);
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; m_acc = 1'b0;
    endtask

    logic [7:0] rd, erd;
    logic       er, eer;

    task automatic test_reset();
        m_reset();
        preset = 1'b1;
        repeat (3) tick();
        n_chk++; if (irq !== 1'b0 || pslverr !== 1'b0 || prdata !== 8'h00)
            $display("FAIL reset_outputs: irq=%b pslverr=%b prdata=%h want 0/0/00", irq, pslverr, prdata);
        else n_pass++;
        preset = 1'b0;
        tick();
        apb(1'b0, 8'h00, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00 || er !== 1'b0)
            $display("FAIL reset_ier: got %h/%b want 00/0", rd, er);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00 || er !== 1'b0)
            $display("FAIL reset_isr: got %h/%b want 00/0", rd, er);
        else n_pass++;
        n_chk++; if (pready !== 1'b1) $display("FAIL pready: got %b want 1", pready);
        else n_pass++;
    endtask

    task automatic test_udf_irq();
        apb(1'b1, 8'h00, 8'h02, 1'b0, rd, er, erd, eer);
        tmr_udf = 1'b1;
        tick();
        n_chk++; if (irq !== 1'b0) $display("FAIL udf_irq_early: got %b want 0", irq);
        else n_pass++;
        tick();
        n_chk++; if (irq !== 1'b1 || irq !== m_irq) $display("FAIL udf_irq_2cyc: got %b want 1", irq);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h02 || rd !== erd) $display("FAIL udf_isr_set: got %h want 02", rd);
        else n_pass++;
        apb(1'b1, 8'h01, 8'h02, 1'b0, rd, er, erd, eer);
        tick();
        n_chk++; if (irq !== 1'b0) $display("FAIL udf_w1c_irq: got %b want 0", irq);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00) $display("FAIL udf_no_reset_while_held: got %h want 00", rd);
        else n_pass++;
        tmr_udf = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        apb(1'b1, 8'h00, 8'h00, 1'b0, rd, er, erd, eer);
        tmr_ovf = 1'b1;
        repeat (3) tick();
        n_chk++; if (irq !== 1'b0) $display("FAIL mask_irq_low: got %b want 0", irq);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h01) $display("FAIL mask_isr_latched: got %h want 01", rd);
        else n_pass++;
        apb(1'b1, 8'h00, 8'h01, 1'b0, rd, er, erd, eer);
        tick();
        n_chk++; if (irq !== 1'b1) $display("FAIL mask_enable_irq: got %b want 1", irq);
        else n_pass++;
        tmr_ovf = 1'b0;
        tick();
    endtask

    task automatic test_set_wins();
        apb(1'b1, 8'h01, 8'h01, 1'b1, rd, er, erd, eer);
        tick();
        n_chk++; if (irq !== 1'b1 || irq !== m_irq) $display("FAIL setwins_irq: got %b want 1", irq);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h01) $display("FAIL setwins_isr: got %h want 01", rd);
        else n_pass++;
        tmr_ovf = 1'b0;
        tick();
    endtask

    task automatic test_unmapped();
        logic [7:0] ier0, isr0;
        ier0 = m_read(8'h00);
        isr0 = m_read(8'h01);
        apb(1'b1, 8'h05, 8'hFF, 1'b0, rd, er, erd, eer);
        n_chk++; if (er !== 1'b1) $display("FAIL unmapped_wr_err: got %b want 1", er);
        else n_pass++;
        apb(1'b0, 8'h05, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (er !== 1'b1 || rd !== 8'h00) $display("FAIL unmapped_rd: got %h/%b want 00/1", rd, er);
        else n_pass++;
        apb(1'b0, 8'h00, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== ier0 || er !== 1'b0) $display("FAIL unmapped_ier_kept: got %h want %h", rd, ier0);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== isr0) $display("FAIL unmapped_isr_kept: got %h want %h", rd, isr0);
        else n_pass++;
    endtask

    task automatic test_counter();
`ifdef TMR_IRQ_CNT_EN
        tmr_ovf = 1'b0; tmr_udf = 1'b0;
        apb(1'b1, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        for (int i = 0; i < 300; i++) begin
            tmr_ovf = 1'b1; tick();
            tmr_ovf = 1'b0; tick();
        end
        apb(1'b0, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'hFF || er !== 1'b0) $display("FAIL icnt_saturate: got %h want ff", rd);
        else n_pass++;
        apb(1'b1, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        apb(1'b0, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00) $display("FAIL icnt_clear: got %h want 00", rd);
        else n_pass++;
        tmr_ovf = 1'b1; tmr_udf = 1'b1;
        tick();
        apb(1'b0, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h02) $display("FAIL icnt_both: got %h want 02", rd);
        else n_pass++;
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd[1:0] !== 2'b11) $display("FAIL isr_both: got %h want x3", rd);
        else n_pass++;
        tmr_ovf = 1'b0; tmr_udf = 1'b0;
        tick();
`else
        apb(1'b0, 8'h02, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (er !== 1'b1 || rd !== 8'h00) $display("FAIL icnt_unmapped: got %h/%b want 00/1", rd, er);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) tmr_ovf = ~tmr_ovf;
            if ($urandom_range(0, 3) == 0) tmr_udf = ~tmr_udf;
            if ($urandom_range(0, 2) == 0) begin
                tick();
            end else begin
                logic       w;
                logic [7:0] a, d;
                w = 1'($urandom_range(0, 1));
                a = 8'($urandom_range(0, 4));
                d = 8'($urandom_range(0, 255));
                apb(w, a, d, 1'b0, rd, er, erd, eer);
                n_chk++; if (er !== eer) $display("FAIL rnd_err[%0d]: addr %h got %b want %b", i, a, er, eer);
                else n_pass++;
                if (!w) begin
                    n_chk++; if (rd !== erd) $display("FAIL rnd_rd[%0d]: addr %h got %h want %h", i, a, rd, erd);
                    else n_pass++;
                end
            end
            n_chk++; if (irq !== m_irq) $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, m_irq);
            else n_pass++;
        end
        tmr_ovf = 1'b0; tmr_udf = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apb(1'b1, 8'h00, 8'h03, 1'b0, rd, er, erd, eer);
        tmr_ovf = 1'b1;
        repeat (3) tick();
        n_chk++; if (irq !== 1'b1) $display("FAIL midrst_pre_irq: got %b want 1", irq);
        else n_pass++;
        #2 preset = 1'b1;
        #1;
        n_chk++; if (irq !== 1'b0) $display("FAIL midrst_async_irq: got %b want 0", irq);
        else n_pass++;
        m_reset();
        repeat (2) tick();
        preset = 1'b0;
        repeat (2) tick();
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00) $display("FAIL midrst_no_false_rise: got %h want 00", rd);
        else n_pass++;
        apb(1'b0, 8'h00, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h00) $display("FAIL midrst_ier_cleared: got %h want 00", rd);
        else n_pass++;
        tmr_ovf = 1'b0; tick();
        tmr_ovf = 1'b1; tick();
        apb(1'b0, 8'h01, 8'h00, 1'b0, rd, er, erd, eer);
        n_chk++; if (rd !== 8'h01) $display("FAIL midrst_rearm: got %h want 01", rd);
        else n_pass++;
        tmr_ovf = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_udf_irq();
        test_mask();
        test_set_wins();
        test_unmapped();
        test_counter();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
